// File: rtl/countdown_timer_4_bit_pkg.sv
// Shared timer definitions: FSM state encoding, counter width and default tick divider.
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int TIMER_WIDTH = 4;
  localparam int DEFAULT_DIV = 50_000_000;
endpackage

// File: rtl/countdown_timer_4_bit_if.sv
// Load handshake and status bundle of the countdown timer; master drives loads, slave is the timer.
interface countdown_timer_4_bit_if #(
  parameter int WIDTH = timer_pkg::TIMER_WIDTH
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, pause, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, pause, abort,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/countdown_timer_4_bit_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every DIV un-held cycles, all logic on clk100mhz.
module tick_gen
  import timer_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk100mhz,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  localparam int            PW   = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  // Tick is combinational so the count moves on the same edge the prescaler wraps.
  assign tick = !clear && !hold && (presc == LAST);

  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (!hold) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer_4_bit.sv
// Loadable down-counter with one-cycle done pulse; define COUNTDOWN_AUTO_RELOAD_EN to restart
// from the last loaded value instead of stopping at zero.
module countdown_timer_4_bit
  import timer_pkg::*;
#(
  parameter int DIV   = DEFAULT_DIV,
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic                   clk100mhz,
  input  logic                   rst,
  countdown_timer_4_bit_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_val;
  logic             busy_flag;
  logic             done_flag;
  logic             load_fire;
  logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_val;
`endif

  assign bus.load_ready = ((state == IDLE) || (state == DONE)) && !bus.abort;
  assign load_fire      = bus.load_valid && bus.load_ready;
  assign bus.count      = count_val;
  assign bus.busy       = busy_flag;
  assign bus.done       = done_flag;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .clear     (bus.abort || load_fire),
    .hold      ((state != RUN) || bus.pause),
    .tick      (tick)
  );

  // Abort outranks everything: it also swallows a tick landing in the same cycle.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count_val  <= '0;
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_val <= '0;
`endif
    end else begin
      done_flag <= 1'b0;
      if (bus.abort) begin
        state     <= IDLE;
        busy_flag <= 1'b0;
      end else if (load_fire) begin
        count_val  <= bus.load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_val <= bus.load_value;
`endif
        if (bus.load_value == '0) begin
          state     <= DONE;
          busy_flag <= 1'b0;
          done_flag <= 1'b1;
        end else begin
          state     <= RUN;
          busy_flag <= 1'b1;
        end
      end else if ((state == RUN) && tick) begin
        if (count_val == ONE) begin
          done_flag <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (reload_val != '0) begin
            count_val <= reload_val;
          end else
`endif
          begin
            count_val <= '0;
            state     <= DONE;
            busy_flag <= 1'b0;
          end
        end else begin
          count_val <= count_val - ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer_4_bit.sv
// Directed bench for countdown_timer_4_bit at DIV=4: vector table plus pause/abort/reset sequences.
module tb_countdown_timer_4_bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  countdown_timer_4_bit_if #(.WIDTH(4)) bus ();

  countdown_timer_4_bit #(.DIV(4), .WIDTH(4)) dut (
    .clk100mhz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [3:0] val;
    logic       p;
    logic       a;
    logic [3:0] cnt;
    logic       bsy;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic lv, logic [3:0] val, logic p, logic a,
                              logic [3:0] cnt, logic bsy, logic dn, logic rdy);
    vec_t v;
    v.lv = lv; v.val = val; v.p = p; v.a = a;
    v.cnt = cnt; v.bsy = bsy; v.dn = dn; v.rdy = rdy;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive inputs for one cycle just after the falling edge, then settle for sampling.
  task automatic step(input logic lv, input logic [3:0] val, input logic p, input logic a);
    @(negedge clk);
    bus.load_valid = lv;
    bus.load_value = val;
    bus.pause      = p;
    bus.abort      = a;
    #1;
  endtask

  task automatic check_all(input string tag, input int cnt, input int bsy, input int dn, input int rdy);
    check({tag, ".count"}, int'(bus.count), cnt);
    check({tag, ".busy"}, int'(bus.busy), bsy);
    check({tag, ".done"}, int'(bus.done), dn);
    check({tag, ".load_ready"}, int'(bus.load_ready), rdy);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.pause      = 1'b0;
    bus.abort      = 1'b0;
    #2;
    check_all("por", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Load 3 at N: 3 from N+1, 2 from N+5, 1 from N+9, 0 with done at N+13.
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    // Load 0 from DONE: done pulses once, busy stays low.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    // Abort in IDLE blocks a load that cycle.
    vecs.push_back(mk(1, 9, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));

    foreach (vecs[i]) begin
      step(vecs[i].lv, vecs[i].val, vecs[i].p, vecs[i].a);
      check_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].bsy, vecs[i].dn, vecs[i].rdy);
    end

    // Load 2, pause during N+2..N+4: count 1 at N+8, 0 and done at N+12.
    step(1, 2, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, (k >= 2 && k <= 4), 0);
      check($sformatf("pause.count@%0d", k), int'(bus.count), (k <= 7) ? 2 : (k <= 11) ? 1 : 0);
      check($sformatf("pause.done@%0d", k), int'(bus.done), (k == 12) ? 1 : 0);
    end
    check("pause.busy_end", int'(bus.busy), 0);

    // Load 5, abort on the tick cycle N+4: count holds 5, then load 1 is accepted.
    step(1, 5, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 0, 0, 0);
    check("abort.pre_count", int'(bus.count), 5);
    step(0, 0, 0, 1);
    check("abort.ready_blocked", int'(bus.load_ready), 0);
    step(1, 1, 0, 0);
    check_all("abort.after", 5, 0, 0, 1);
    step(0, 0, 0, 0);
    check_all("reload1", 1, 1, 0, 0);
    for (int k = 7; k <= 9; k++) step(0, 0, 0, 0);
    check("reload1.pre_done", int'(bus.done), 0);
    step(0, 0, 0, 0);
    check_all("reload1.done", 0, 0, 1, 1);
`else
    // Auto reload, load 2: done every 8 cycles, count 2,1,2,1...
    step(1, 2, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      step(0, 0, 0, 0);
      check($sformatf("auto.count@%0d", k), int'(bus.count), (((k - 1) % 8) < 4) ? 2 : 1);
      check($sformatf("auto.done@%0d", k), int'(bus.done), (k == 9 || k == 17) ? 1 : 0);
      check($sformatf("auto.busy@%0d", k), int'(bus.busy), 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("auto.abort_busy", int'(bus.busy), 0);
    check("auto.abort_ready", int'(bus.load_ready), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("auto.abort_no_done", int'(bus.done), 0);
`endif

    // Asynchronous reset in the middle of a run, sampled before the next rising edge.
    step(1, 7, 0, 0);
    for (int k = 1; k <= 5; k++) step(0, 0, 0, 0);
    check("midrun.busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);
    check_all("post_rst", 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
